sfx_event_sequencer: RTL and testbench
======================================

# sfx_event_sequencer

Upstream front-end for the audio processing unit. It synchronises the raw collision inputs (sheep/dragon, sword/dragon, player/dragon), detects rising edges, latches them as pending requests and arbitrates them by priority. It then holds one clean one-hot sound-effect request for a fixed number of video frames. The APU consumes the one-hot levels and the frame index instead of the raw `ui_in` bits.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth per collision input (≥2).
- `CNT_W`, 6: width of the frame counter.
- `DUR_SHEEP`, 8: effect length in frames, sheep/dragon (1..2^CNT_W).
- `DUR_SWORD`, 12: effect length in frames, sword/dragon (1..2^CNT_W).
- `DUR_PLAYER`, 30: effect length in frames, player/dragon (1..2^CNT_W).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `frame_tick`  in  1: one-cycle pulse per video frame, synchronous to `clk`.
- `sheep_hit_i`  in  1: raw sheep/dragon collision, asynchronous.
- `sword_hit_i`  in  1: raw sword/dragon collision, asynchronous.
- `player_hit_i`  in  1: raw player/dragon collision, asynchronous.
- `sfx_sheep`  out  1: effect request level to the APU.
- `sfx_sword`  out  1: effect request level to the APU.
- `sfx_player`  out  1: effect request level to the APU.
- `sfx_id`  out  2: active effect; 0 = none, 1 = sheep, 2 = sword, 3 = player.
- `sfx_frame`  out  CNT_W: frames elapsed in the current effect.
- `busy`  out  1: high in PLAY.
- `pending`  out  3: latched, unserved requests as {player, sword, sheep}.

## Operation
- Synchroniser and edge detect:
  - Each input passes through a SYNC_STAGES flop chain.
  - A rise is the synchronised value high while the previous synchronised value was low.
  - A rise sets the matching `pending` bit. Levels held high produce no further rises.
- Priority: player > sword > sheep.
- FSM states: IDLE and PLAY.
  - **IDLE:** if any `pending` bit is set, take the highest one. Clear that bit, load `sfx_id`, clear `sfx_frame` to 0, go to PLAY. Otherwise stay in IDLE.
  - **PLAY, effect ends:** when `frame_tick` arrives and `sfx_frame == DUR(sfx_id) - 1`, go to IDLE and set `sfx_id` to 0.
  - **PLAY, frame advance:** on any other `frame_tick`, `sfx_frame` increments by 1. It never wraps, because the end condition fires first.
  - **PLAY, preemption:** a pending bit of higher priority than `sfx_id` is taken immediately in place of the current effect. Clear that bit, load the new id, set `sfx_frame` to 0, stay in PLAY. The preempted effect is dropped, not re-queued.
  - **PLAY, retrigger:** a rise of the active effect's own input restarts it (`sfx_frame` to 0) and does not set its pending bit.
  - **PLAY, lower priority:** a rise of a lower-priority input sets its pending bit, which is served after the current effect ends.
- Simultaneous events:
  - Several rises in one cycle are all latched; the highest is served first.
  - A rise and a clear of the same pending bit in one cycle: the set wins.
  - Start or preemption in the same cycle as `frame_tick`: the load wins, `sfx_frame` = 0, and the tick is ignored.
- Outputs:
  - `sfx_sheep`, `sfx_sword` and `sfx_player` decode `sfx_id` one-hot; all three are 0 when `sfx_id` = 0.
  - `busy` = (`sfx_id` != 0).
  - All outputs are registered; there are no combinational input-to-output paths.
- Reset, whether asserted at any point or mid-effect: FSM to IDLE; `sfx_id`, `sfx_frame`, `pending`, synchroniser flops and edge history all to 0. All outputs read 0 while `rst_n` is low.

## Timing
- Rise to output:
  - An input rise first sampled high at edge k sets its `pending` bit at edge k+SYNC_STAGES.
  - From IDLE, the effect outputs assert at edge k+SYNC_STAGES+1, i.e. 3 cycles with the default.
  - In the same cycle the `pending` bit clears.
- Duration: exactly DUR `frame_tick` pulses after the start. The outputs deassert on the clock edge that samples the final tick.
- Back-to-back:
  - A pending request queued behind an effect starts one cycle after the return to IDLE.
  - This gives exactly one idle cycle with `sfx_id` = 0.
- Preemption: the new id appears one cycle after its `pending` bit is set, with no idle gap.

## Test plan
- Reset, then pulse `sheep_hit_i` high for 5 cycles (SYNC_STAGES = 2, one tick every 100 cycles) -> `sfx_sheep` rises 3 cycles after the input rise; it stays high for exactly 8 ticks with `sfx_frame` 0..7, then falls and `sfx_id` = 0.
- `sheep_hit_i` and `sword_hit_i` rise in the same cycle -> sword plays 12 ticks while `pending` = 3'b001; then one idle cycle; then sheep plays 8 ticks and `pending` = 0.
- Sword effect at `sfx_frame` = 5, then `player_hit_i` rises -> `sfx_id` = 3 with `sfx_frame` = 0 and no idle gap; the player effect lasts 30 ticks; sword is not replayed.
- Player effect at `sfx_frame` = 20, then a second `player_hit_i` rise -> `sfx_frame` restarts at 0 and the effect runs 30 more ticks; `pending` stays 0.
- Input held high for 200 ticks -> exactly one effect is produced; no retrigger while the input stays high.
- `rst_n` pulled low mid-effect, asynchronous to `clk` -> all outputs go to 0 immediately; after release with inputs low, the block stays in IDLE.

Source files
------------

// File: rtl/sfx_event_sequencer_if.sv
// Sound-effect request bundle from the event sequencer to the APU: one-hot
// levels, active id and frame index, plus status.
interface sfx_event_sequencer_if #(
  parameter int CNT_W = 6
);
  logic             sfx_sheep;
  logic             sfx_sword;
  logic             sfx_player;
  logic [1:0]       sfx_id;
  logic [CNT_W-1:0] sfx_frame;
  logic             busy;
  logic [2:0]       pending;

  modport master (
    output sfx_sheep, sfx_sword, sfx_player, sfx_id, sfx_frame, busy, pending
  );

  modport slave (
    input sfx_sheep, sfx_sword, sfx_player, sfx_id, sfx_frame, busy, pending
  );
endinterface

// File: rtl/sfx_event_sequencer.sv
// Collision-to-sound-effect front end: synchronises raw hits, latches rises as
// pending requests and plays the highest-priority effect for a fixed frame count.
module sfx_event_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6,
  parameter int DUR_SHEEP   = 8,
  parameter int DUR_SWORD   = 12,
  parameter int DUR_PLAYER  = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 sheep_hit_i,
  input  logic                 sword_hit_i,
  input  logic                 player_hit_i,
  sfx_event_sequencer_if.master sfx
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [CNT_W-1:0] LAST_SHEEP  = CNT_W'(DUR_SHEEP - 1);
  localparam logic [CNT_W-1:0] LAST_SWORD  = CNT_W'(DUR_SWORD - 1);
  localparam logic [CNT_W-1:0] LAST_PLAYER = CNT_W'(DUR_PLAYER - 1);

  // Bit order everywhere is {player, sword, sheep}; id n maps to bit n-1,
  // so a numerically larger id is also the higher priority.
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       hist_q;
  logic [2:0]       rise;

  state_t           state_q, state_d;
  logic [1:0]       id_q, id_d, top_id;
  logic [CNT_W-1:0] frame_q, frame_d, last_frame;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       id_mask, set_mask, clr_mask;

  function automatic logic [2:0] id_onehot(input logic [1:0] id);
    return {id == 2'd3, id == 2'd2, id == 2'd1};
  endfunction

  // NOTE: the synchroniser array is a handful of flops, not a RAM, so it is
  // safe (and required) to clear it on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= {player_hit_i, sword_hit_i, sheep_hit_i};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // NOTE: every signal gets a default before any branch so no latch can form.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    frame_d  = frame_q;
    clr_mask = '0;

    if (pend_q[2])      top_id = 2'd3;
    else if (pend_q[1]) top_id = 2'd2;
    else if (pend_q[0]) top_id = 2'd1;
    else                top_id = 2'd0;

    case (id_q)
      2'd1:    last_frame = LAST_SHEEP;
      2'd2:    last_frame = LAST_SWORD;
      2'd3:    last_frame = LAST_PLAYER;
      default: last_frame = '0;
    endcase

    // A rise of the effect already playing restarts it instead of queueing.
    id_mask  = id_onehot(id_q);
    set_mask = rise & ~id_mask;

    // Covers both a start from IDLE (id 0) and preemption of a lower effect.
    if (top_id > id_q) begin
      clr_mask = id_onehot(top_id);
      id_d     = top_id;
      frame_d  = '0;
      state_d  = PLAY;
    end else if (state_q == PLAY) begin
      if (|(rise & id_mask)) begin
        frame_d = '0;
      end else if (frame_tick) begin
        if (frame_q == last_frame) begin
          id_d    = 2'd0;
          state_d = IDLE;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
    end

    // Set beats clear when a rise lands on the bit being served.
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      id_q           <= '0;
      frame_q        <= '0;
      pend_q         <= '0;
      sfx.sfx_sheep  <= 1'b0;
      sfx.sfx_sword  <= 1'b0;
      sfx.sfx_player <= 1'b0;
      sfx.busy       <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      frame_q        <= frame_d;
      pend_q         <= pend_d;
      sfx.sfx_sheep  <= (id_d == 2'd1);
      sfx.sfx_sword  <= (id_d == 2'd2);
      sfx.sfx_player <= (id_d == 2'd3);
      sfx.busy       <= (state_d == PLAY);
    end
  end

  assign sfx.sfx_id    = id_q;
  assign sfx.sfx_frame = frame_q;
  assign sfx.pending   = pend_q;

endmodule

// File: tb/tb_sfx_event_sequencer.sv
// Self-checking bench for sfx_event_sequencer: directed scenarios plus random
// hits/ticks/resets, all compared every cycle against a queue-based reference.
module tb_sfx_event_sequencer;

  localparam int S  = 2;
  localparam int CW = 6;
  localparam int DS = 8;
  localparam int DW = 12;
  localparam int DP = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic sheep_hit_i = 1'b0;
  logic sword_hit_i = 1'b0;
  logic player_hit_i = 1'b0;

  sfx_event_sequencer_if #(.CNT_W(CW)) sfx ();

  sfx_event_sequencer #(
    .SYNC_STAGES(S), .CNT_W(CW), .DUR_SHEEP(DS), .DUR_SWORD(DW), .DUR_PLAYER(DP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .sheep_hit_i  (sheep_hit_i),
    .sword_hit_i  (sword_hit_i),
    .player_hit_i (player_hit_i),
    .sfx          (sfx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_period = 10;
  logic last_tick;
  logic [2:0] cur_raw = 3'b000;

  // Reference: raw sample history, pending set, active id and ticks remaining.
  logic [2:0] m_hist[$];
  logic [2:0] m_pend;
  int m_id;
  int m_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int dur(input int id);
    case (id)
      1: return DS;
      2: return DW;
      3: return DP;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_hist = {};
    repeat (S + 2) m_hist.push_front(3'b000);
    m_pend = 3'b000;
    m_id = 0;
    m_left = 0;
  endtask

  task automatic model_step(input logic [2:0] raw, input logic ft);
    logic [2:0] rise, own, set, clr;
    int top;
    m_hist.push_front(raw);
    while (m_hist.size() > S + 2) void'(m_hist.pop_back());
    // An input sampled at edge e-S becomes a visible rise acted on at edge e.
    rise = m_hist[S] & ~m_hist[S+1];
    top = m_pend[2] ? 3 : m_pend[1] ? 2 : m_pend[0] ? 1 : 0;
    own = (m_id != 0) ? 3'(1 << (m_id - 1)) : 3'b000;
    set = rise & ~own;
    clr = 3'b000;
    if (top > m_id) begin
      clr = 3'(1 << (top - 1));
      m_id = top;
      m_left = dur(top);
    end else if (m_id != 0 && (rise & own) != 3'b000) begin
      m_left = dur(m_id);
    end else if (m_id != 0 && ft) begin
      m_left--;
      if (m_left == 0) m_id = 0;
    end
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic check_outputs();
    check("sfx_id", sfx.sfx_id, m_id);
    check("busy", sfx.busy, m_id != 0);
    check("sfx_sheep", sfx.sfx_sheep, m_id == 1);
    check("sfx_sword", sfx.sfx_sword, m_id == 2);
    check("sfx_player", sfx.sfx_player, m_id == 3);
    check("pending", sfx.pending, m_pend);
    if (m_id != 0) check("sfx_frame", sfx.sfx_frame, dur(m_id) - m_left);
  endtask

  task automatic run_cycle();
    logic ft;
    if (tick_period > 0) ft = ((cyc % tick_period) == (tick_period - 1));
    else ft = ($urandom_range(0, 5) == 0);
    last_tick = ft;
    {player_hit_i, sword_hit_i, sheep_hit_i} = cur_raw;
    frame_tick = ft;
    @(posedge clk);
    model_step(cur_raw, ft);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  // Reset asserted off the clock edge; outputs must clear without waiting for clk.
  task automatic do_reset();
    @(negedge clk);
    cur_raw = 3'b000;
    {player_hit_i, sword_hit_i, sheep_hit_i} = 3'b000;
    frame_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_id", sfx.sfx_id, 0);
    check("rst_frame", sfx.sfx_frame, 0);
    check("rst_pending", sfx.pending, 0);
    check("rst_busy", sfx.busy, 0);
    check("rst_onehot", {sfx.sfx_player, sfx.sfx_sword, sfx.sfx_sheep}, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sfx.busy && n < 5000) begin run_cycle(); n++; end
    check(tag, sfx.busy, 0);
  endtask

  initial begin
    int k, lat, n, ticks, starts;
    bit found, prev_busy;

    model_reset();
    do_reset();
    repeat (10) run_cycle();

    // Sheep pulse: 3-cycle latency, 8 ticks, frames checked by the model.
    tick_period = 100;
    k = cyc; found = 0; lat = -1;
    cur_raw = 3'b001;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      if (!found && sfx.sfx_sheep) begin found = 1; lat = cyc - 1 - k; end
    end
    cur_raw = 3'b000;
    check("s1_latency", lat, 3);
    ticks = 0; n = 0;
    while (sfx.sfx_sheep && n < 5000) begin run_cycle(); ticks += last_tick; n++; end
    check("s1_ticks", ticks, DS);
    check("s1_idle_id", sfx.sfx_id, 0);

    // Sheep and sword together: sword first, one idle cycle, then sheep.
    tick_period = 10;
    repeat (5) run_cycle();
    cur_raw = 3'b011;
    repeat (3) run_cycle();
    cur_raw = 3'b000;
    n = 0;
    while (!sfx.sfx_sword && n < 50) begin run_cycle(); n++; end
    check("s2_sword_start", sfx.sfx_sword, 1);
    check("s2_pend_sheep", sfx.pending, 3'b001);
    n = 0;
    while (sfx.sfx_sword && n < 5000) begin run_cycle(); n++; end
    check("s2_gap_id", sfx.sfx_id, 0);
    run_cycle();
    check("s2_sheep_next", sfx.sfx_id, 1);
    check("s2_pend_empty", sfx.pending, 0);
    drain("s2_drain");

    // Sword preempted by player at frame 5; sword is not replayed.
    cur_raw = 3'b010;
    repeat (2) run_cycle();
    cur_raw = 3'b000;
    n = 0;
    while (!(sfx.sfx_sword && sfx.sfx_frame == 5) && n < 500) begin run_cycle(); n++; end
    check("s3_sword_f5", sfx.sfx_frame, 5);
    cur_raw = 3'b100;
    n = 0;
    while (sfx.sfx_id == 2 && n < 20) begin run_cycle(); n++; end
    check("s3_preempt_id", sfx.sfx_id, 3);
    check("s3_preempt_frame", sfx.sfx_frame, 0);
    cur_raw = 3'b000;
    ticks = 0; n = 0;
    while (sfx.sfx_player && n < 5000) begin run_cycle(); ticks += last_tick; n++; end
    check("s3_player_ticks", ticks, DP);
    repeat (20) run_cycle();
    check("s3_no_replay", sfx.busy, 0);

    // Player retriggered at frame 20 runs a full 30 more ticks.
    cur_raw = 3'b100;
    repeat (2) run_cycle();
    cur_raw = 3'b000;
    n = 0;
    while (!(sfx.sfx_player && sfx.sfx_frame == 20) && n < 1000) begin run_cycle(); n++; end
    check("s4_player_f20", sfx.sfx_frame, 20);
    repeat (2) run_cycle();
    cur_raw = 3'b100;
    n = 0;
    while (sfx.sfx_frame != 0 && n < 20) begin run_cycle(); n++; end
    check("s4_restart_frame", sfx.sfx_frame, 0);
    check("s4_restart_id", sfx.sfx_id, 3);
    check("s4_pend", sfx.pending, 0);
    cur_raw = 3'b000;
    ticks = 0; n = 0;
    while (sfx.sfx_player && n < 5000) begin run_cycle(); ticks += last_tick; n++; end
    check("s4_ticks", ticks, DP);

    // Input held high for 200 ticks gives exactly one effect.
    repeat (5) run_cycle();
    cur_raw = 3'b010;
    starts = 0; prev_busy = sfx.busy;
    for (int i = 0; i < 200 * 10; i++) begin
      run_cycle();
      if (sfx.busy && !prev_busy) starts++;
      prev_busy = sfx.busy;
    end
    check("s5_starts", starts, 1);
    cur_raw = 3'b000;
    drain("s5_drain");

    // Reset mid-effect, then stay idle with inputs low.
    cur_raw = 3'b100;
    repeat (2) run_cycle();
    cur_raw = 3'b000;
    repeat (50) run_cycle();
    check("s6_mid_effect", sfx.sfx_player, 1);
    do_reset();
    repeat (30) run_cycle();
    check("s6_idle", sfx.busy, 0);

    // Random hits, ticks and occasional resets.
    tick_period = 0;
    for (int i = 0; i < 8000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 11) == 0) cur_raw[b] = ~cur_raw[b];
      if ($urandom_range(0, 2999) == 0) do_reset();
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
